// File: rtl/uart_rx_edge_sampler_if.sv
// Signal bundle between the UART receive FSM (master) and the edge sampler (slave).
// The FSM drives line, enables and prescale; the sampler returns counters and voted bits.
interface uart_rx_edge_sampler_if;
  logic       rx_in;
  logic       enable;
  logic       dat_samp_en;
  logic [5:0] prescale;
  logic       rx_sync;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       samp_valid;
  logic       cfg_err;

  modport master (
    output rx_in, enable, dat_samp_en, prescale,
    input  rx_sync, edge_cnt, bit_cnt, sampled_bit, samp_valid, cfg_err
  );

  modport slave (
    input  rx_in, enable, dat_samp_en, prescale,
    output rx_sync, edge_cnt, bit_cnt, sampled_bit, samp_valid, cfg_err
  );
endinterface

// File: rtl/uart_rx_edge_sampler.sv
// UART oversample edge/bit counter with 3-point majority vote; rx_sync lags rx_in by SYNC_STAGES clocks,
// sampled_bit/samp_valid appear at edge P/2+2. No backpressure: samp_valid is a one-cycle pulse.
module uart_rx_edge_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  uart_rx_edge_sampler_if.slave bus
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_sync;
  logic                   enable_q;
  logic                   run_q;
  logic [5:0]             p_q;
  logic                   cfg_err_q;
  logic [4:0]             edge_q;
  logic [3:0]             bit_q;
  logic                   s0_q;
  logic                   s1_q;
  logic                   got0_q;
  logic                   got1_q;
  logic                   sampled_q;
  logic                   valid_q;

  logic       start;
  logic       active;
  logic       legal;
  logic [5:0] ec6;
  logic [5:0] half;
  logic       at_wrap;
  logic       vote;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx_in};
  end

  assign rx_sync = sync_q[SYNC_STAGES-1];

  // enable_q resets high so an enable held through reset is not seen as a rising edge
  assign start   = bus.enable & ~enable_q;
  assign active  = bus.enable & (run_q | ~enable_q);
  assign legal   = (bus.prescale == 6'd8) || (bus.prescale == 6'd16) || (bus.prescale == 6'd32);
  assign ec6     = {1'b0, edge_q};
  assign half    = p_q >> 1;
  assign at_wrap = (ec6 == p_q - 6'd1);
  assign vote    = (s0_q & s1_q) | (s0_q & rx_sync) | (s1_q & rx_sync);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q  <= 1'b1;
      run_q     <= 1'b0;
      p_q       <= 6'd8;
      cfg_err_q <= 1'b0;
      edge_q    <= '0;
      bit_q     <= '0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      got0_q    <= 1'b0;
      got1_q    <= 1'b0;
      sampled_q <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      enable_q <= bus.enable;
      run_q    <= active;
      valid_q  <= 1'b0;

      if (start) begin
        p_q       <= legal ? bus.prescale : 6'd8;
        cfg_err_q <= ~legal;
      end

      if (!active) begin
        edge_q <= '0;
        bit_q  <= '0;
        got0_q <= 1'b0;
        got1_q <= 1'b0;
      end else begin
        if (at_wrap) begin
          edge_q <= '0;
          if (bit_q != 4'd15) bit_q <= bit_q + 4'd1;
        end else begin
          edge_q <= edge_q + 5'd1;
        end

        // got0/got1 chain ensures a vote only follows two consecutive captured samples
        if (!bus.dat_samp_en) begin
          got0_q <= 1'b0;
          got1_q <= 1'b0;
        end else if (ec6 == half - 6'd1) begin
          s0_q   <= rx_sync;
          got0_q <= 1'b1;
          got1_q <= 1'b0;
        end else if (ec6 == half) begin
          if (got0_q) s1_q <= rx_sync;
          got1_q <= got0_q;
          got0_q <= 1'b0;
        end else if (ec6 == half + 6'd1) begin
          if (got1_q) begin
            sampled_q <= vote;
            valid_q   <= 1'b1;
          end
          got0_q <= 1'b0;
          got1_q <= 1'b0;
        end
      end
    end
  end

  assign bus.rx_sync     = rx_sync;
  assign bus.edge_cnt    = edge_q;
  assign bus.bit_cnt     = bit_q;
  assign bus.sampled_bit = sampled_q;
  assign bus.samp_valid  = valid_q;
  assign bus.cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// Directed stimulus for the edge sampler; a negedge monitor scores every samp_valid against a queue.
module tb_uart_rx_edge_sampler;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct packed {
    logic       bit_v;
    logic [4:0] edge_v;
  } exp_t;

  exp_t exp_q[$];
  logic [2:0] pats [4];

  uart_rx_edge_sampler_if bus ();

  uart_rx_edge_sampler #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start(input logic [5:0] ps);
    bus.prescale = ps;
    bus.enable   = 1'b1;
  endtask

  task automatic stop();
    bus.enable = 1'b0;
    cyc();
  endtask

  // rx_sync value wanted at cycle j of the pattern test (P=8)
  function automatic logic want(input int j);
    int b;
    int e;
    b = j / 8;
    e = j % 8;
    if (b < 4 && e >= 3 && e <= 5) return pats[b][5-e];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (bus.samp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got samp_valid=1 at edge_cnt %0d, expected none", bus.edge_cnt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.sampled_bit !== e.bit_v || bus.edge_cnt !== e.edge_v) begin
          n_bad++;
          $display("FAIL vote: got bit %0d at edge %0d, expected bit %0d at edge %0d",
                   bus.sampled_bit, bus.edge_cnt, e.bit_v, e.edge_v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    pats[0] = 3'b010;
    pats[1] = 3'b101;
    pats[2] = 3'b011;
    pats[3] = 3'b100;

    reset_n         = 1'b0;
    bus.rx_in       = 1'b1;
    bus.enable      = 1'b0;
    bus.dat_samp_en = 1'b0;
    bus.prescale    = 6'd8;
    repeat (3) cyc();
    chk("rst_edge", bus.edge_cnt, 0);
    chk("rst_bit", bus.bit_cnt, 0);
    chk("rst_sampled", bus.sampled_bit, 1);
    chk("rst_valid", bus.samp_valid, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);
    chk("rst_rx_sync", bus.rx_sync, 1);
    reset_n = 1'b1;
    repeat (2) cyc();

    // free-running count at P=8
    start(6'd8);
    for (int k = 1; k <= 40; k++) begin
      cyc();
      chk("run8_edge", bus.edge_cnt, k % 8);
      chk("run8_bit", bus.bit_cnt, k / 8);
    end
    stop();
    chk("idle_edge", bus.edge_cnt, 0);
    chk("idle_bit", bus.bit_cnt, 0);

    // bit_cnt saturation
    start(6'd8);
    repeat (160) cyc();
    chk("sat_bit", bus.bit_cnt, 15);
    chk("sat_edge", bus.edge_cnt, 0);
    stop();

    // illegal prescale, ignored change while enabled, relatch legal
    start(6'd12);
    cyc();
    chk("p12_cfg_err", bus.cfg_err, 1);
    repeat (6) cyc();
    chk("p12_edge7", bus.edge_cnt, 7);
    bus.prescale = 6'd32;
    cyc();
    chk("p12_wrap_edge", bus.edge_cnt, 0);
    chk("p12_wrap_bit", bus.bit_cnt, 1);
    repeat (7) cyc();
    chk("p12_edge7b", bus.edge_cnt, 7);
    cyc();
    chk("p12_wrap_bit2", bus.bit_cnt, 2);
    stop();
    start(6'd32);
    cyc();
    chk("p32_cfg_err", bus.cfg_err, 0);
    repeat (30) cyc();
    chk("p32_edge31", bus.edge_cnt, 31);
    cyc();
    chk("p32_wrap_edge", bus.edge_cnt, 0);
    chk("p32_wrap_bit", bus.bit_cnt, 1);
    stop();

    // P=16, line held low: votes at edges 7,8,9, valid at 10
    bus.rx_in = 1'b0;
    repeat (3) cyc();
    bus.dat_samp_en = 1'b1;
    exp_q.push_back('{bit_v: 1'b0, edge_v: 5'd10});
    exp_q.push_back('{bit_v: 1'b0, edge_v: 5'd10});
    start(6'd16);
    repeat (32) cyc();
    chk("p16_bit", bus.bit_cnt, 2);
    chk("p16_sampled", bus.sampled_bit, 0);
    stop();
    bus.dat_samp_en = 1'b0;

    // majority patterns at P=8
    bus.rx_in = 1'b1;
    repeat (3) cyc();
    bus.dat_samp_en = 1'b1;
    exp_q.push_back('{bit_v: 1'b0, edge_v: 5'd6});
    exp_q.push_back('{bit_v: 1'b1, edge_v: 5'd6});
    exp_q.push_back('{bit_v: 1'b1, edge_v: 5'd6});
    exp_q.push_back('{bit_v: 1'b0, edge_v: 5'd6});
    start(6'd8);
    for (int k = 0; k < 32; k++) begin
      bus.rx_in = want(k + 2);
      cyc();
    end
    stop();
    chk("maj_last", bus.sampled_bit, 0);

    // partial samples discarded: dat_samp_en drop, then enable drop
    bus.rx_in = 1'b1;
    repeat (3) cyc();
    start(6'd8);
    repeat (4) cyc();
    bus.dat_samp_en = 1'b0;
    repeat (12) cyc();
    chk("drop_en_hold", bus.sampled_bit, 0);
    bus.dat_samp_en = 1'b1;
    repeat (5) cyc();
    stop();
    repeat (5) cyc();
    chk("drop_enable_hold", bus.sampled_bit, 0);
    bus.dat_samp_en = 1'b0;

    // reset mid-frame at bit 3 edge 5
    bus.rx_in = 1'b0;
    repeat (3) cyc();
    bus.dat_samp_en = 1'b1;
    exp_q.push_back('{bit_v: 1'b0, edge_v: 5'd6});
    exp_q.push_back('{bit_v: 1'b0, edge_v: 5'd6});
    exp_q.push_back('{bit_v: 1'b0, edge_v: 5'd6});
    start(6'd12);
    repeat (29) cyc();
    chk("pre_rst_edge", bus.edge_cnt, 5);
    chk("pre_rst_bit", bus.bit_cnt, 3);
    chk("pre_rst_cfg", bus.cfg_err, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_edge", bus.edge_cnt, 0);
    chk("mid_rst_bit", bus.bit_cnt, 0);
    chk("mid_rst_sampled", bus.sampled_bit, 1);
    chk("mid_rst_valid", bus.samp_valid, 0);
    chk("mid_rst_cfg", bus.cfg_err, 0);
    chk("mid_rst_rx_sync", bus.rx_sync, 1);
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (4) cyc();
    chk("post_rst_hold_edge", bus.edge_cnt, 0);
    chk("post_rst_hold_bit", bus.bit_cnt, 0);
    stop();
    start(6'd8);
    repeat (3) cyc();
    chk("post_rst_count", bus.edge_cnt, 3);
    stop();
    bus.dat_samp_en = 1'b0;
    repeat (2) cyc();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
